// File: rtl/mips_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package mips_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } md_state_t;

  // Signed ops take operand magnitudes and sign-correct in FIXUP.
  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between ID/EX and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  cancel;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_data, rt_data, cancel,
    input  busy, done, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_data, rt_data, cancel,
    output busy, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/md_datapath.sv
// Accumulator with one shift-add (multiply) or restoring-divide step per cycle.
// Layout: acc = {carry/remainder-top, HI half, LO half}; LO is the
// multiplier (shifted out) or the dividend (shifted into quotient).
module md_datapath #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  isDiv,
  input  logic [DATA_WIDTH-1:0] loadLow,
  input  logic [DATA_WIDTH-1:0] loadOperand,
  output logic [DATA_WIDTH-1:0] accHi,
  output logic [DATA_WIDTH-1:0] accLo
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned ACC_W = 2 * DATA_WIDTH + 1;

  logic [ACC_W-1:0] accQ;
  logic [ACC_W-1:0] mulNext;
  logic [ACC_W-1:0] divNext;
  logic [W-1:0]     operandQ;
  logic [W:0]       mulUpper;
  logic [W:0]       remShift;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  always_comb begin
    mulUpper = accQ[ACC_W-1:W];
    if (accQ[0]) begin
      mulUpper = mulUpper + {1'b0, operandQ};
    end
    mulNext = {1'b0, mulUpper, accQ[W-1:1]};
  end

  // Divide step: shift left, trial subtract divisor, shift in the quotient bit.
  always_comb begin
    remShift = accQ[2*W-1:W-1];
    if (remShift >= {1'b0, operandQ}) begin
      divNext = {remShift - {1'b0, operandQ}, accQ[W-2:0], 1'b1};
    end else begin
      divNext = {remShift, accQ[W-2:0], 1'b0};
    end
  end

  // Accumulator and operand (multiplicand / divisor) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accQ     <= '0;
      operandQ <= '0;
    end else if (load) begin
      accQ     <= {{(W + 1){1'b0}}, loadLow};
      operandQ <= loadOperand;
    end else if (step) begin
      accQ     <= isDiv ? divNext : mulNext;
    end
  end

  assign accHi = accQ[2*W-1:W];
  assign accLo = accQ[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave mdIf
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  md_state_t        stateQ, stateNext;
  logic [CNT_W-1:0] counterQ;
  logic             isDivQ, negResultQ, negRemQ, zeroDivQ;
  logic [W-1:0]     hiQ, loQ;
  logic             busyQ, doneQ, dbzQ;

  logic             isMulOp, isDivOp, signedOp, rsNeg, rtNeg, rtZero, accept;
  logic [W-1:0]     rsMag, rtMag;

  logic             dpLoad, dpStep;
  logic [W-1:0]     dpLoadLow, dpLoadOperand, dpHi, dpLo;
  logic [2*W-1:0]   productFix;
  logic             hiWe, loWe, busyNext, doneNext, dbzNext;
  logic [W-1:0]     hiNext, loNext;

  md_datapath #(.DATA_WIDTH(W)) dataPath (
    .clk         (clk),
    .reset       (reset),
    .load        (dpLoad),
    .step        (dpStep),
    .isDiv       (isDivQ),
    .loadLow     (dpLoadLow),
    .loadOperand (dpLoadOperand),
    .accHi       (dpHi),
    .accLo       (dpLo)
  );

  // Decode the presented op and take operand magnitudes for signed ops.
  always_comb begin
    isMulOp  = (mdIf.op == OP_MULT) || (mdIf.op == OP_MULTU);
    isDivOp  = (mdIf.op == OP_DIV)  || (mdIf.op == OP_DIVU);
    signedOp = isSignedOp(mdIf.op);
    rsNeg    = signedOp && mdIf.rs_data[W-1];
    rtNeg    = signedOp && mdIf.rt_data[W-1];
    rsMag    = rsNeg ? W'(-mdIf.rs_data) : mdIf.rs_data;
    rtMag    = rtNeg ? W'(-mdIf.rt_data) : mdIf.rt_data;
    rtZero   = (mdIf.rt_data == '0);
    accept   = (stateQ == IDLE) && mdIf.start && !mdIf.cancel;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next-state logic; cancel abandons any in-flight op.
  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (accept && isMulOp) begin
          stateNext = MUL;
        end else if (accept && isDivOp) begin
          stateNext = rtZero ? FIXUP : DIV;
        end
      end
      MUL, DIV: begin
        if (mdIf.cancel) begin
          stateNext = IDLE;
        end else if (counterQ == CNT_W'(W - 1)) begin
          stateNext = FIXUP;
        end
      end
      FIXUP:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output/control logic: datapath load/step, sign fix-up and HI/LO commit.
  always_comb begin
    dpLoad        = 1'b0;
    dpStep        = 1'b0;
    dpLoadLow     = '0;
    dpLoadOperand = '0;
    hiWe          = 1'b0;
    loWe          = 1'b0;
    hiNext        = hiQ;
    loNext        = loQ;
    doneNext      = 1'b0;
    dbzNext       = 1'b0;
    busyNext      = (stateNext != IDLE);
    productFix    = negResultQ ? (2*W)'(-{dpHi, dpLo}) : {dpHi, dpLo};
    unique case (stateQ)
      IDLE: begin
        if (accept && (mdIf.op == OP_MTHI)) begin
          hiWe   = 1'b1;
          hiNext = mdIf.rs_data;
        end else if (accept && (mdIf.op == OP_MTLO)) begin
          loWe   = 1'b1;
          loNext = mdIf.rs_data;
        end else if (accept && isMulOp) begin
          dpLoad        = 1'b1;
          dpLoadLow     = rtMag;
          dpLoadOperand = rsMag;
        end else if (accept && isDivOp) begin
          // A zero divisor parks the raw dividend in LO for the HI write-back.
          dpLoad        = 1'b1;
          dpLoadLow     = rtZero ? mdIf.rs_data : rsMag;
          dpLoadOperand = rtMag;
        end
      end
      MUL, DIV: begin
        dpStep = !mdIf.cancel;
      end
      FIXUP: begin
        if (!mdIf.cancel) begin
          hiWe     = 1'b1;
          loWe     = 1'b1;
          doneNext = 1'b1;
          dbzNext  = zeroDivQ;
          if (zeroDivQ) begin
            hiNext = dpLo;
            loNext = '1;
          end else if (isDivQ) begin
            hiNext = negRemQ    ? W'(-dpHi) : dpHi;
            loNext = negResultQ ? W'(-dpLo) : dpLo;
          end else begin
            hiNext = productFix[2*W-1:W];
            loNext = productFix[W-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Per-op flags and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isDivQ     <= 1'b0;
      negResultQ <= 1'b0;
      negRemQ    <= 1'b0;
      zeroDivQ   <= 1'b0;
      counterQ   <= '0;
    end else if (accept && (isMulOp || isDivOp)) begin
      isDivQ     <= isDivOp;
      negResultQ <= rsNeg ^ rtNeg;
      negRemQ    <= rsNeg;
      zeroDivQ   <= isDivOp && rtZero;
      counterQ   <= '0;
    end else if (dpStep) begin
      counterQ   <= counterQ + CNT_W'(1);
    end
  end

  // Architectural HI/LO and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiQ   <= '0;
      loQ   <= '0;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
      dbzQ  <= 1'b0;
    end else begin
      if (hiWe) hiQ <= hiNext;
      if (loWe) loQ <= loNext;
      busyQ <= busyNext;
      doneQ <= doneNext;
      dbzQ  <= dbzNext;
    end
  end

  assign mdIf.busy        = busyQ;
  assign mdIf.done        = doneQ;
  assign mdIf.div_by_zero = dbzQ;
  assign mdIf.hi_out      = hiQ;
  assign mdIf.lo_out      = loQ;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [W-1:0] mHi, mLo;

  mult_div_unit_if #(.DATA_WIDTH(W)) mdIf ();

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .mdIf  (mdIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void refOp(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    h = '0; l = '0; z = 1'b0;
    case (o)
      OP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      OP_MULTU: begin u = {32'b0, a} * {32'b0, b}; h = u[63:32]; l = u[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          h = a; l = '1; z = 1'b1;
        end else if (o == OP_DIV) begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    mdIf.start = 1'b1; mdIf.op = o; mdIf.rs_data = a; mdIf.rt_data = b;
    @(posedge clk); #1;
    mdIf.start = 1'b0; mdIf.op = 3'd0;
  endtask

  // Count edges until done; busy must stay high and HI/LO unchanged meanwhile.
  task automatic waitDone(input int c0, output int lat, output bit holdOk);
    int c;
    c = c0;
    holdOk = 1'b1;
    while (mdIf.done !== 1'b1 && c < 200) begin
      if (mdIf.busy !== 1'b1 || mdIf.hi_out !== mHi || mdIf.lo_out !== mLo) holdOk = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    lat = c;
  endtask

  task automatic runOp(input string tag, input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic ez;
    int lat;
    bit holdOk;
    refOp(o, a, b, eh, el, ez);
    issue(o, a, b);
    waitDone(0, lat, holdOk);
    check({tag, "_latency"}, 64'(lat), ez ? 64'd1 : 64'(W + 1));
    check({tag, "_hold"}, 64'(holdOk), 64'd1);
    check({tag, "_busy_at_done"}, 64'(mdIf.busy), 64'd0);
    check({tag, "_dbz"}, 64'(mdIf.div_by_zero), 64'(ez));
    check({tag, "_hi"}, 64'(mdIf.hi_out), 64'(eh));
    check({tag, "_lo"}, 64'(mdIf.lo_out), 64'(el));
    mHi = eh; mLo = el;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'b0, mdIf.done, mdIf.div_by_zero}, 64'd0);
  endtask

  initial begin
    int lat;
    bit holdOk;
    bit sawDone;
    total = 0; bad = 0; mHi = '0; mLo = '0;
    reset = 1'b1;
    mdIf.start = 1'b0; mdIf.op = 3'd0; mdIf.rs_data = '0; mdIf.rt_data = '0; mdIf.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_status", {61'b0, mdIf.busy, mdIf.done, mdIf.div_by_zero}, 64'd0);
    check("reset_hilo", {mdIf.hi_out, mdIf.lo_out}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic corners.
    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi_const", 64'(mHi), 64'hFFFF_FFFE);
    runOp("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_lo_const", 64'(mLo), 64'hFFFF_FFF1);
    runOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo_const", 64'(mLo), 64'hFFFF_FFFD);
    runOp("divu_zero", OP_DIVU, 32'd100, 32'd0);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("div_rem_neg", OP_DIV, 32'd7, 32'hFFFF_FFFE);

    // MTHI/MTLO: immediate write, never busy.
    issue(OP_MTHI, 32'h1234, 32'h0);
    check("mthi_busy", 64'(mdIf.busy), 64'd0);
    check("mthi_hi", 64'(mdIf.hi_out), 64'h1234);
    mHi = 32'h1234;
    issue(OP_MTLO, 32'h5678, 32'h0);
    check("mtlo_status", {62'b0, mdIf.busy, mdIf.done}, 64'd0);
    check("mtlo_hilo", {mdIf.hi_out, mdIf.lo_out}, {32'h1234, 32'h5678});
    mLo = 32'h5678;

    // Undefined and OP_NONE codes are ignored.
    issue(3'd7, 32'hDEAD_BEEF, 32'h3);
    issue(OP_NONE, 32'hDEAD_BEEF, 32'h3);
    check("undef_busy", 64'(mdIf.busy), 64'd0);
    check("undef_hilo", {mdIf.hi_out, mdIf.lo_out}, {mHi, mLo});

    // Start while busy is dropped.
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    issue(OP_DIVU, 32'd1000, 32'd3);
    waitDone(5, lat, holdOk);
    check("busy_start_latency", 64'(lat), 64'(W + 1));
    check("busy_start_hilo", {mdIf.hi_out, mdIf.lo_out}, {32'd0, 32'd42});
    mHi = 32'd0; mLo = 32'd42;
    @(posedge clk); #1;
    check("busy_start_no_second", {62'b0, mdIf.busy, mdIf.done}, 64'd0);

    // Cancel at cycle 10 of a MULT.
    issue(OP_MULT, 32'h0001_0000, 32'h0003_0000);
    repeat (9) begin @(posedge clk); #1; end
    check("cancel_busy_before", 64'(mdIf.busy), 64'd1);
    mdIf.cancel = 1'b1;
    @(posedge clk); #1;
    mdIf.cancel = 1'b0;
    check("cancel_busy_after", 64'(mdIf.busy), 64'd0);
    sawDone = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (mdIf.done !== 1'b0) sawDone = 1'b1; end
    check("cancel_no_done", 64'(sawDone), 64'd0);
    check("cancel_hilo", {mdIf.hi_out, mdIf.lo_out}, {mHi, mLo});

    // Cancel together with start in IDLE.
    mdIf.cancel = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd0);
    mdIf.cancel = 1'b0;
    check("cancel_start_busy", 64'(mdIf.busy), 64'd0);
    @(posedge clk); #1;
    check("cancel_start_done", {62'b0, mdIf.done, mdIf.div_by_zero}, 64'd0);

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      md_op_t o;
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(1, 4);
      o = md_op_t'(3'(sel));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = b & 32'hFF;
        1: a = a & 32'hFFFF;
        2: if (i % 3 == 0) b = '0;
        default: ;
      endcase
      runOp($sformatf("rand%0d", i), o, a, b);
    end

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'd12345, 32'd17);
    repeat (5) begin @(posedge clk); #1; end
    #3 reset = 1'b1;
    #1;
    check("midreset_status", {61'b0, mdIf.busy, mdIf.done, mdIf.div_by_zero}, 64'd0);
    check("midreset_hilo", {mdIf.hi_out, mdIf.lo_out}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (mdIf.done !== 1'b0 || mdIf.busy !== 1'b0) sawDone = 1'b1; end
    check("midreset_quiet", 64'(sawDone), 64'd0);
    mHi = '0; mLo = '0;
    runOp("post_reset", OP_MULTU, 32'd1000, 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
